rom_burst_reader: RTL
=====================

ROM_BURST_READER -- requirements
Module: rom_burst_reader

Interface
REQ-001 Parameter DW, default 16: ROM data word width in bits.
REQ-002 Parameter AW, default 7: ROM address width in bits.
REQ-003 Parameter CW, default 8: burst word-count width in bits.
REQ-004 Parameter DEPTH, default 4: FIFO depth in words; power of two, >=2.
REQ-005 Clocking: one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  block clock (gated ROM clock domain).
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 i_rd_rom  in  1  burst request strobe, one cycle.
REQ-009 i_addr_rom  in  AW  burst start address.
REQ-010 i_wordcnt_rom  in  CW  number of words to read.
REQ-011 i_abort_rom  in  1  cancel the burst and flush the FIFO.
REQ-012 i_pop_rom  in  1  consumer pops the FIFO head.
REQ-013 o_data_rom  out  DW  FIFO head word (first-word fall-through).
REQ-014 o_empty_rom / o_fifo_full_rom  out  1 each  FIFO empty / full flags.
REQ-015 o_busy_rom  out  1  burst in progress.
REQ-016 o_done_rom  out  1  one-cycle pulse at burst completion.
REQ-017 o_err_rom  out  1  one-cycle pulse on bound violation (ROM_BOUND_CHECK_EN only; otherwise tied 0).
REQ-018 CEN / A / Q  out 1 / out AW / in DW  synchronous ROM port; CEN is active-low; Q is valid in the cycle after the cycle in which CEN is low.

Function
REQ-019 States: IDLE, FETCH, FLUSH; the block SHALL be in IDLE after reset.
REQ-020 In IDLE, i_rd_rom SHALL latch the address and count, assert o_busy_rom and enter FETCH.
REQ-021 i_rd_rom while not in IDLE SHALL be ignored.
REQ-022 A request with wordcnt=0 SHALL pulse o_done_rom on the next cycle, perform no ROM access and stay in IDLE.
REQ-023 Issue rule: in FETCH, CEN=0 with A=current address SHALL be driven in any cycle where remaining>0 and (fifo_count+inflight)<DEPTH; after each issue the address increments and remaining decrements.
REQ-024 The word read by an issue SHALL be pushed into the FIFO on the next clock edge, giving sustained throughput of 1 word/cycle when popped continuously.
REQ-025 First-word latency: o_empty_rom SHALL deassert 2 cycles after the edge that samples i_rd_rom.
REQ-026 CEN SHALL be 1 in every cycle with no issue; A holds its last value.
REQ-027 Completion: when remaining=0 and inflight=0, the block SHALL pulse o_done_rom for one cycle, deassert o_busy_rom and return to IDLE; FIFO contents are retained.
REQ-028 A pop with push in the same cycle SHALL leave fifo_count unchanged; a pop when empty SHALL be ignored.
REQ-029 The full condition is reached only through the issue rule; o_fifo_full_rom = (fifo_count==DEPTH).
REQ-030 i_abort_rom in any state SHALL enter FLUSH for one cycle: drop the in-flight word, empty the FIFO, clear busy, no done pulse, then return to IDLE.
REQ-031 Abort together with i_rd_rom in the same cycle: abort SHALL win and the request SHALL be dropped.

Reset
REQ-032 With rst_n=0 at a clock edge: CEN=1, A=0, o_data_rom=0, o_empty_rom=1, o_fifo_full_rom=0, o_busy_rom=0, o_done_rom=0, o_err_rom=0; FIFO pointers, count, inflight and remaining cleared; state IDLE.
REQ-033 Reset asserted mid-burst SHALL abandon the burst with no done or err pulse.

Configuration
REQ-034 Macro ROM_BOUND_CHECK_EN defined: a request with addr+wordcnt > 2^AW SHALL be rejected: o_err_rom pulses next cycle, no ROM access, state stays IDLE.
REQ-035 Macro ROM_BOUND_CHECK_EN undefined: the address SHALL wrap modulo 2^AW and o_err_rom SHALL be constant 0.

Verification
REQ-036 addr=0x10, cnt=3, pop held 1 -> CEN low for 3 consecutive cycles at A=0x10,0x11,0x12; words popped in order; done pulse once.
REQ-037 addr=0x00, cnt=8, DEPTH=4, no pops -> exactly 4 issues, full=1, busy=1; pop 1 word -> exactly 1 further issue.
REQ-038 cnt=0 -> done the next cycle, CEN stays 1 throughout, empty stays 1.
REQ-039 addr=0x7E, cnt=4, AW=7 -> with macro: err pulse, no access; without macro: A=0x7E,0x7F,0x00,0x01.
REQ-040 Abort issued after the 2nd issue of cnt=6 -> empty=1 and busy=0 in 2 cycles; no done; a new request is then accepted normally.
REQ-041 rst_n=0 for 1 cycle mid-burst -> all outputs at reset values on the next cycle; no done or err pulse.

Source files
------------

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: issues burst reads to a synchronous ROM (active-low CEN,
// data returned one cycle after the access) and buffers the returned words in
// a small first-word-fall-through FIFO for the consumer.
// Optional feature: define ROM_BOUND_CHECK_EN to reject requests whose
// address range runs past the end of the ROM (o_err_rom pulses). Without it
// addresses wrap modulo 2^AW and o_err_rom is tied low.
module rom_burst_reader #(
    parameter int DW    = 16,
    parameter int AW    = 7,
    parameter int CW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_rd_rom,
    input  logic [AW-1:0] i_addr_rom,
    input  logic [CW-1:0] i_wordcnt_rom,
    input  logic          i_abort_rom,
    input  logic          i_pop_rom,
    output logic [DW-1:0] o_data_rom,
    output logic          o_empty_rom,
    output logic          o_fifo_full_rom,
    output logic          o_busy_rom,
    output logic          o_done_rom,
    output logic          o_err_rom,
    output logic          CEN,
    output logic [AW-1:0] A,
    input  logic [DW-1:0] Q
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Burst control
    logic [AW-1:0] addr_q;
    logic [AW-1:0] a_last_q;
    logic [CW-1:0] remaining_q;
    logic          inflight_q;
    logic          done_q;

    // FIFO storage
    logic [DW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CNTW-1:0] count_q;

    logic req_seen;
    logic req_ok;
    logic bound_bad;
    logic fifo_room;
    logic issue;
    logic complete;
    logic push_ok;
    logic pop_ok;

    // A request is only considered in IDLE, and abort always takes priority
    assign req_seen  = (state_q == IDLE) && i_rd_rom && !i_abort_rom;
    assign req_ok    = req_seen && (i_wordcnt_rom != '0) && !bound_bad;

    // Reserve a FIFO slot for the word still in flight so a push never overflows
    assign fifo_room = (count_q + CNTW'(inflight_q)) < CNTW'(DEPTH);
    assign issue     = rst_n && !i_abort_rom && (state_q == FETCH) &&
                       (remaining_q != '0) && fifo_room;
    assign complete  = (state_q == FETCH) && (remaining_q == '0) && !inflight_q;

    assign push_ok   = inflight_q && !i_abort_rom;
    assign pop_ok    = i_pop_rom && (count_q != '0);

`ifdef ROM_BOUND_CHECK_EN
    localparam int SW = AW + CW + 1;
    localparam logic [SW-1:0] ROM_WORDS = SW'(1) << AW;

    logic [SW-1:0] bound_sum;
    logic          err_q;

    assign bound_sum = SW'(i_addr_rom) + SW'(i_wordcnt_rom);
    assign bound_bad = bound_sum > ROM_WORDS;

    // One-cycle error pulse for a rejected out-of-range request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= req_seen && (i_wordcnt_rom != '0) && bound_bad;
        end
    end

    assign o_err_rom = err_q;
`else
    assign bound_bad = 1'b0;
    assign o_err_rom = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (i_abort_rom) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE:    if (req_ok) state_d = FETCH;
                FETCH:   if (complete) state_d = IDLE;
                FLUSH:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ROM port and status outputs; A holds the last issued address when idle
    always_comb begin
        CEN        = ~issue;
        A          = issue ? addr_q : a_last_q;
        o_busy_rom = (state_q == FETCH);
    end

    // Burst address/count tracking, in-flight flag and done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            a_last_q    <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            inflight_q <= issue;
            done_q     <= !i_abort_rom &&
                          ((req_seen && (i_wordcnt_rom == '0)) || complete);
            if (i_abort_rom) begin
                remaining_q <= '0;
            end else if (req_ok) begin
                addr_q      <= i_addr_rom;
                remaining_q <= i_wordcnt_rom;
            end else if (issue) begin
                addr_q      <= addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end
            if (issue) begin
                a_last_q <= addr_q;
            end
        end
    end

    // FIFO data storage; unreset so it can map onto plain memory
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= Q;
        end
    end

    // FIFO pointers and occupancy; abort empties the FIFO
    always_ff @(posedge clk) begin
        if (!rst_n || i_abort_rom) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head word is masked to zero while empty so reset leaves a defined output
    assign o_empty_rom     = (count_q == '0);
    assign o_fifo_full_rom = (count_q == CNTW'(DEPTH));
    assign o_data_rom      = o_empty_rom ? '0 : mem[rd_ptr_q];
    assign o_done_rom      = done_q;

endmodule
